// File: rtl/frame_reader.sv
// Scan-out reader: fetches frame-buffer chunks through the DDR address/read-data FIFOs,
// buffers returned 128-bit beats and streams 24-bit RGB pixels in raster order.
module frame_reader #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int BUF_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  frame_base,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  output logic [2:0]   af_cmd_din,
  input  logic         rdf_valid,
  input  logic [127:0] rdf_dout,
  output logic         rdf_rd_en,
  output logic [23:0]  video,
  output logic         video_valid,
  input  logic         video_ready
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(BUF_DEPTH - 2);
  localparam logic [9:0]  LAST_X     = 10'(H_ACTIVE - 8);
  localparam logic [9:0]  LAST_Y     = 10'(V_ACTIVE - 1);

  typedef enum logic {REQ_IDLE, REQ_ISSUE} req_state_e;

  req_state_e     state_q;
  logic [9:0]     req_x_q, req_x_d, req_y_q, req_y_d;
  logic [5:0]     base_q, base_d, base_use;
  logic [CW-1:0]  in_flight_q, in_flight_d, words_q, words_d;
  logic [CW:0]    credit_sum;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]     pix_q, pix_d;
  logic [23:0]    video_q, video_d;
  logic           video_valid_q, video_valid_d;
  logic [127:0]   mem [BUF_DEPTH];
  logic [127:0]   head;
  logic           issue, pop, load, free, first_chunk;
  logic           unused_base_bits;

  assign unused_base_bits = ^{frame_base[31:28], frame_base[21:0]};

  // Credits cover both buffered words and beats still in flight, so a pop always has room.
  assign credit_sum  = {1'b0, words_q} + {1'b0, in_flight_q};
  assign issue       = !rst && (state_q == REQ_ISSUE) && !af_full && (credit_sum <= CREDIT_MAX);
  assign pop         = rdf_valid && !rst;
  assign first_chunk = (req_x_q == 10'd0) && (req_y_q == 10'd0);
  assign base_use    = first_chunk ? frame_base[27:22] : base_q;

  assign af_wr_en    = issue;
  assign af_addr_din = {6'b0, base_use, req_y_q, req_x_q[9:3], 2'b00};
  assign af_cmd_din  = 3'b001;
  assign rdf_rd_en   = pop;
  assign video       = video_q;
  assign video_valid = video_valid_q;

  assign head = mem[rd_ptr_q];
  assign load = (!video_valid_q || video_ready) && (words_q != '0);
  assign free = load && (pix_q == 2'd3);

  always_comb begin
    req_x_d = req_x_q;
    req_y_d = req_y_q;
    base_d  = base_q;
    if (issue) begin
      if (first_chunk) base_d = frame_base[27:22];
      if (req_x_q == LAST_X) begin
        req_x_d = 10'd0;
        req_y_d = (req_y_q == LAST_Y) ? 10'd0 : req_y_q + 10'd1;
      end else begin
        req_x_d = req_x_q + 10'd8;
      end
    end
    in_flight_d = in_flight_q + (issue ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    words_d     = words_q + (pop ? CW'(1) : CW'(0)) - (free ? CW'(1) : CW'(0));
    wr_ptr_d    = pop  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = free ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  // Output register: reload whenever empty or the current pixel is being taken.
  always_comb begin
    video_d       = video_q;
    video_valid_d = video_valid_q;
    pix_d         = pix_q;
    if (load) begin
      video_d       = head[{pix_q, 5'b0} +: 24];
      video_valid_d = 1'b1;
      pix_d         = pix_q + 2'd1;
    end else if (video_ready) begin
      video_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= REQ_IDLE;
      req_x_q       <= '0;
      req_y_q       <= '0;
      base_q        <= '0;
      in_flight_q   <= '0;
      words_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pix_q         <= '0;
      video_q       <= '0;
      video_valid_q <= 1'b0;
    end else begin
      case (state_q)
        REQ_IDLE:  state_q <= REQ_ISSUE;
        REQ_ISSUE: state_q <= REQ_ISSUE;
        default:   state_q <= REQ_IDLE;
      endcase
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      base_q        <= base_d;
      in_flight_q   <= in_flight_d;
      words_q       <= words_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pix_q         <= pix_d;
      video_q       <= video_d;
      video_valid_q <= video_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) mem[wr_ptr_q] <= rdf_dout;
  end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader with a small frame, a fixed-latency DDR model and
// raster/address/credit monitors.
module tb_frame_reader;
  localparam int H = 64;
  localparam int V = 4;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  frame_base;
  logic         af_full;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic [2:0]   af_cmd_din;
  logic         rdf_valid = 1'b0;
  logic [127:0] rdf_dout = '0;
  logic         rdf_rd_en;
  logic [23:0]  video;
  logic         video_valid;
  logic         video_ready;

  frame_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .frame_base(frame_base), .af_full(af_full),
    .af_wr_en(af_wr_en), .af_addr_din(af_addr_din), .af_cmd_din(af_cmd_din),
    .rdf_valid(rdf_valid), .rdf_dout(rdf_dout), .rdf_rd_en(rdf_rd_en),
    .video(video), .video_valid(video_valid), .video_ready(video_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input logic [5:0] b, input int y, input int x);
    return {b[3:0], 10'(y), 10'(x)};
  endfunction

  // DDR model: each pushed read returns its two beats a few clocks later.
  typedef struct { logic [30:0] addr; int due; } req_t;
  req_t         reqq[$];
  logic [127:0] beatq[$];
  int           cyc = 0;
  logic         s_push, s_pop, s_rst;
  logic [30:0]  s_addr;

  always begin
    @(negedge clk);
    s_push = af_wr_en; s_addr = af_addr_din; s_pop = rdf_rd_en; s_rst = rst;
    @(posedge clk); #1;
    cyc++;
    if (s_rst) begin
      reqq.delete(); beatq.delete();
    end else begin
      if (s_pop && beatq.size() > 0) beatq.delete(0);
      if (s_push) reqq.push_back('{s_addr, cyc + 2});
    end
    while (reqq.size() > 0 && reqq[0].due <= cyc) begin
      logic [30:0]  a;
      logic [127:0] w;
      a = reqq[0].addr;
      for (int bt = 0; bt < 2; bt++) begin
        for (int k = 0; k < 4; k++)
          w[32*k +: 32] = {8'hC3, pix(a[24:19], int'(a[18:9]), int'(a[8:2]) * 8 + bt * 4 + k)};
        beatq.push_back(w);
      end
      reqq.delete(0);
    end
    rdf_valid = (beatq.size() > 0);
    rdf_dout  = rdf_valid ? beatq[0] : '0;
  end

  // Monitors: address sequence, raster pixel stream, hold-while-stalled, credit bound.
  int         ex_x, ex_y, ox, oy, frames, n_push, n_acc;
  logic [5:0] cur_base, pb;
  logic [5:0] base_fifo[$];
  logic       prev_stall;
  logic [23:0] prev_video;

  always @(negedge clk) begin
    if (rst) begin
      ex_x = 0; ex_y = 0; ox = 0; oy = 0; frames = 0; n_push = 0; n_acc = 0;
      cur_base = '0; pb = '0; base_fifo.delete(); prev_stall = 1'b0;
    end else begin
      chk("credits", 64'(2 * n_push - (n_acc + int'(video_valid)) / 4 <= D), 64'd1);
      if (prev_stall) begin
        chk("hold_valid", 64'(video_valid), 64'd1);
        chk("hold_video", 64'(video), 64'(prev_video));
      end
      if (af_wr_en) begin
        if (ex_x == 0 && ex_y == 0) begin
          cur_base = frame_base[27:22];
          base_fifo.push_back(cur_base);
        end
        chk("af_addr", 64'(af_addr_din), 64'({6'b0, cur_base, 10'(ex_y), 7'(ex_x / 8), 2'b00}));
        chk("af_cmd", 64'(af_cmd_din), 64'd1);
        n_push++;
        ex_x += 8;
        if (ex_x == H) begin ex_x = 0; ex_y++; if (ex_y == V) ex_y = 0; end
      end
      if (video_valid && video_ready) begin
        if (ox == 0 && oy == 0 && base_fifo.size() > 0) pb = base_fifo.pop_front();
        chk("video", 64'(video), 64'(pix(pb, oy, ox)));
        n_acc++;
        ox++;
        if (ox == H) begin ox = 0; oy++; if (oy == V) begin oy = 0; frames++; end end
      end
      prev_stall = video_valid && !video_ready;
      prev_video = video;
    end
  end

  int t;

  initial begin
    rst = 1'b1; frame_base = 32'h0040_0000; af_full = 1'b0; video_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_af_wr_en", 64'(af_wr_en), 64'd0);
    chk("rst_rdf_rd_en", 64'(rdf_rd_en), 64'd0);
    chk("rst_video_valid", 64'(video_valid), 64'd0);
    chk("rst_video", 64'(video), 64'd0);

    // 1: idle cycle after reset, then first chunk with base 1
    rst = 1'b0;
    chk("idle_no_req", 64'(af_wr_en), 64'd0);
    @(posedge clk); #1;
    chk("first_req", 64'(af_wr_en), 64'd1);
    chk("first_addr", 64'(af_addr_din), 64'h0008_0000);
    for (t = 0; t < 200 && n_acc < 8; t++) begin @(posedge clk); #1; end
    chk("first8_timeout", 64'(t < 200), 64'd1);

    // 2: whole frame delivered, then monitor sees the request wrap to (0,0)
    for (t = 0; t < 5000 && frames < 1; t++) begin @(posedge clk); #1; end
    chk("frame_timeout", 64'(t < 5000), 64'd1);
    chk("frame_pixels", 64'(n_acc), 64'(H * V));

    // 3: address FIFO full mid-line
    for (t = 0; t < 2000 && !(ex_x == 32 && ex_y == 1); t++) begin @(posedge clk); #1; end
    chk("midline_timeout", 64'(t < 2000), 64'd1);
    af_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("af_full_block", 64'(af_wr_en), 64'd0);
    end
    af_full = 1'b0;

    // 4: sink stalls, buffer fills and requests stop
    repeat (10) @(posedge clk);
    #1;
    video_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("stall_no_req", 64'(af_wr_en), 64'd0);
    chk("stall_valid", 64'(video_valid), 64'd1);
    video_ready = 1'b1;

    // 5: base change mid-frame only affects the next frame
    for (t = 0; t < 2000 && ex_x == 0; t++) begin @(posedge clk); #1; end
    frame_base = 32'h0080_0000;
    for (t = 0; t < 5000 && !(af_wr_en && af_addr_din[18:2] == 17'd0); t++) begin @(posedge clk); #1; end
    chk("newframe_timeout", 64'(t < 5000), 64'd1);
    chk("new_base", 64'(af_addr_din[24:19]), 64'd2);
    repeat (100) @(posedge clk);
    #1;

    // 6: one-cycle reset mid-line restarts at (0,0)
    for (t = 0; t < 2000 && ex_x != 24; t++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst6_video_valid", 64'(video_valid), 64'd0);
    chk("rst6_video", 64'(video), 64'd0);
    chk("rst6_af_wr_en", 64'(af_wr_en), 64'd0);
    chk("rst6_rdf_rd_en", 64'(rdf_rd_en), 64'd0);
    rst = 1'b0;
    chk("rst6_idle", 64'(af_wr_en), 64'd0);
    @(posedge clk); #1;
    chk("rst6_req", 64'(af_wr_en), 64'd1);
    chk("rst6_addr", 64'(af_addr_din), 64'h0010_0000);
    for (t = 0; t < 5000 && frames < 1; t++) begin @(posedge clk); #1; end
    chk("rst6_frame_timeout", 64'(t < 5000), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
